handshake_const_eq_buffered: RTL and testbench
==============================================

Name: handshake_const_eq_buffered

Overview:
- Consumer-side counterpart of the constant-source operator: accepts data tokens on a handshake input channel and compares each against a compile-time constant (default all-ones).
- Emits the 1-bit equality result as a token on a handshake output channel.
- Result is held in a 2-slot skid buffer, so latency is 1 cycle, throughput is 1 token/cycle, and `ins_ready` is registered to break the combinational ready path.
- Sits in dataflow circuits wherever a loop-exit or sentinel test against a constant is needed.

Parameters:
- DATA_WIDTH, 32: width of the `ins` data.
- CONST_VALUE, {DATA_WIDTH{1'b1}} (32'hFFFFFFFF at default width): constant that `ins` is compared against.
- COUNT_WIDTH, 16: width of `match_count`; only used when HANDSHAKE_CONST_EQ_STATS_EN is defined.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ins  input  DATA_WIDTH  input data token.
- ins_valid  input  1  input token valid.
- ins_ready  output  1  block can accept a token.
- result  output  1  1 when the token equals CONST_VALUE, else 0.
- result_valid  output  1  result token valid.
- result_ready  input  1  downstream accepts the result.
- match_count  output  COUNT_WIDTH  saturating count of matches; present only with HANDSHAKE_CONST_EQ_STATS_EN.

Behaviour:
- Transfer definitions:
  - accept = ins_valid & ins_ready.
  - send = result_valid & result_ready.
  - eq = (ins == CONST_VALUE), full-width unsigned compare.
- Reset: synchronous, active-high.
  - Next edge: state <= EMPTY, main_q <= 0, skid_q <= 0.
  - While rst is high, ins_ready = 0 and result_valid = 0 (gated), and result = 0.
  - The first cycle after rst deasserts shows ins_ready = 1 and result_valid = 0.
  - Reset mid-operation discards any buffered tokens; none are emitted afterwards.
- Output decode (all from registers, no combinational input-to-output path):
  - result_valid = (state != EMPTY).
  - result = main_q.
  - ins_ready = (state != FULL).
- State machine, 3 states:
  - EMPTY:
    - accept -> ONE, main_q <= eq.
    - otherwise stay.
  - ONE:
    - accept & !send -> FULL, skid_q <= eq.
    - !accept & send -> EMPTY.
    - accept & send -> ONE, main_q <= eq (simultaneous events keep full throughput).
    - neither -> hold.
  - FULL (ins_ready = 0, so no accept is possible):
    - send -> ONE, main_q <= skid_q.
    - otherwise hold.
- Latency and ordering:
  - A token accepted at edge N is visible on result/result_valid in the cycle after N.
  - Tokens leave in strict FIFO order.
- Stability: while result_valid = 1 and result_ready = 0, result stays constant until the send.
- ins and ins_valid may change freely when ins_ready = 0; nothing is captured.

Optional Feature:
- Macro: HANDSHAKE_CONST_EQ_STATS_EN.
- Defined:
  - match_count port exists.
  - Increments by 1 on every accept with eq = 1.
  - Saturates at all-ones and does not wrap.
  - Cleared to 0 by rst.
  - Counts at accept time, not send time.
- Undefined: no port, no counter logic. Handshake behaviour is identical in both builds.

Decomposition:
- Shared package handshake_pkg:
  - State encoding typedef: EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2.
  - Default all-ones constant helper.
  - Transfer-condition naming (accept/send) used across the handshake library.
- One natural sub-module: handshake_skid_buffer_2.
  - Generic 2-slot registered-ready buffer, parameterised on width.
  - Instantiated with width 1 here; the comparator and the optional counter stay in the top.

Test Plan:
- Reset/idle: hold rst 3 cycles with ins_valid = 1.
  - During reset: ins_ready = 0, result_valid = 0.
  - After release: ins_ready = 1, result_valid = 0, no token emitted.
- Streaming, result_ready = 1:
  - Send 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF on consecutive cycles.
  - Results 1, 0, 0, 1 appear one cycle after each accept, with no bubbles.
- Backpressure fill: result_ready = 0, then offer 32'hFFFFFFFF, then 32'h5.
  - Both are accepted; ins_ready drops to 0 the cycle after the second accept.
  - A third token is held off.
  - On result_ready = 1, results 1 and then 0 drain, and ins_ready returns to 1 after the first send.
- Simultaneous accept and send in ONE: alternate result_ready each cycle under continuous input.
  - No token is lost or duplicated and order is preserved (scoreboard over 1000 random tokens, ~25% equal to the constant).
- Mid-operation reset: with FULL holding results 1 and 1, assert rst for 1 cycle.
  - result_valid = 0 afterwards; neither stale result ever appears.
  - With STATS_EN, match_count reads 0.
- STATS_EN saturation: COUNT_WIDTH = 4, 20 matching tokens.
  - match_count reaches 15 and stays 15.
  - Non-matching tokens never change it.

Source files
------------

// File: rtl/handshake_pkg.sv
// -----------------------------------------------------------------------------
// handshake_pkg
// Shared definitions for the handshake operator library:
//   - hs_state_e   : occupancy state of a 2-slot registered-ready buffer
//   - all_ones()   : default all-ones constant helper
//   - hs_accept()  : input-side transfer condition (valid & ready)
//   - hs_send()    : output-side transfer condition (valid & ready)
// No ports (package).
// -----------------------------------------------------------------------------
package handshake_pkg;

    // Widest constant the all_ones helper can produce.
    localparam int unsigned MAX_CONST_WIDTH = 64;

    // Buffer occupancy: no token, one token in main slot, both slots in use.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } hs_state_e;

    // All-ones pattern of the requested width (right-aligned, zero above).
    function automatic logic [MAX_CONST_WIDTH-1:0] all_ones(input int unsigned width);
        logic [MAX_CONST_WIDTH-1:0] ones;
        ones = {MAX_CONST_WIDTH{1'b1}};
        if (width >= MAX_CONST_WIDTH) begin
            return ones;
        end else begin
            return ones >> (MAX_CONST_WIDTH - width);
        end
    endfunction

    // A token moves into a block on the input channel.
    function automatic logic hs_accept(input logic valid, input logic ready);
        return valid & ready;
    endfunction

    // A token leaves a block on the output channel.
    function automatic logic hs_send(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage : handshake_pkg

// File: rtl/handshake_skid_buffer_2.sv
// -----------------------------------------------------------------------------
// handshake_skid_buffer_2
// Generic 2-slot buffer with a registered ready. Latency 1, throughput 1
// token/cycle; in_ready depends only on state, so no combinational path runs
// from out_ready back to in_ready.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (also gates the outputs)
//   in_data    in   WIDTH   incoming token payload
//   in_valid   in   incoming token valid
//   in_ready   out  buffer can take a token (not FULL)
//   out_data   out  WIDTH   head-of-buffer payload
//   out_valid  out  head-of-buffer valid (not EMPTY)
//   out_ready  in   downstream takes the head token
// -----------------------------------------------------------------------------
module handshake_skid_buffer_2
    import handshake_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    hs_state_e        state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept_s;
    logic             send_s;

    // Outputs decode from registers only; rst forces the channel quiet.
    assign in_ready  = (state_q != FULL) & ~rst;
    assign out_valid = (state_q != EMPTY) & ~rst;
    assign out_data  = rst ? {WIDTH{1'b0}} : main_q;

    assign accept_s = hs_accept(in_valid, in_ready);
    assign send_s   = hs_send(out_valid, out_ready);

    // Next-state and slot update logic.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept_s) begin
                    state_d = ONE;
                    main_d  = in_data;
                end else begin
                    state_d = EMPTY;
                end
            end
            ONE: begin
                if (accept_s && !send_s) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (!accept_s && send_s) begin
                    state_d = EMPTY;
                end else if (accept_s && send_s) begin
                    // Head leaves while the new token replaces it directly.
                    state_d = ONE;
                    main_d  = in_data;
                end else begin
                    state_d = ONE;
                end
            end
            FULL: begin
                // in_ready is low here, so only a send can happen.
                if (send_s) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State and slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= {WIDTH{1'b0}};
            skid_q  <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule : handshake_skid_buffer_2

// File: rtl/handshake_const_eq_buffered.sv
// -----------------------------------------------------------------------------
// handshake_const_eq_buffered
// Compares each accepted input token against CONST_VALUE and emits the 1-bit
// equality result through a 2-slot registered-ready buffer (latency 1,
// throughput 1 token/cycle).
// Optional build macro: HANDSHAKE_CONST_EQ_STATS_EN adds COUNT_WIDTH and the
// match_count output (saturating count of matching accepts).
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   ins           in   DATA_WIDTH  input data token
//   ins_valid     in   input token valid
//   ins_ready     out  block can accept a token
//   result        out  1 when the token equals CONST_VALUE
//   result_valid  out  result token valid
//   result_ready  in   downstream accepts the result
//   match_count   out  COUNT_WIDTH (stats build only)
// -----------------------------------------------------------------------------
module handshake_const_eq_buffered
    import handshake_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] CONST_VALUE = DATA_WIDTH'(all_ones(DATA_WIDTH))
`ifdef HANDSHAKE_CONST_EQ_STATS_EN
    ,
    parameter int unsigned COUNT_WIDTH = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic                  result,
    output logic                  result_valid,
    input  logic                  result_ready
`ifdef HANDSHAKE_CONST_EQ_STATS_EN
    ,
    output logic [COUNT_WIDTH-1:0] match_count
`endif
);

    logic eq_s;

    // Full-width unsigned comparison against the constant.
    assign eq_s = (ins == CONST_VALUE);

    handshake_skid_buffer_2 #(
        .WIDTH (1)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_data   (eq_s),
        .in_valid  (ins_valid),
        .in_ready  (ins_ready),
        .out_data  (result),
        .out_valid (result_valid),
        .out_ready (result_ready)
    );

`ifdef HANDSHAKE_CONST_EQ_STATS_EN
    logic                   accept_s;
    logic [COUNT_WIDTH-1:0] match_count_q, match_count_d;

    assign accept_s    = hs_accept(ins_valid, ins_ready);
    assign match_count = match_count_q;

    // Count matches at accept time, holding at all-ones instead of wrapping.
    always_comb begin
        match_count_d = match_count_q;
        if (accept_s && eq_s && (match_count_q != {COUNT_WIDTH{1'b1}})) begin
            match_count_d = match_count_q + COUNT_WIDTH'(1);
        end else begin
            match_count_d = match_count_q;
        end
    end

    // Match counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_count_q <= {COUNT_WIDTH{1'b0}};
        end else begin
            match_count_q <= match_count_d;
        end
    end
`endif

endmodule : handshake_const_eq_buffered

// File: tb/tb_handshake_const_eq_buffered.sv
// -----------------------------------------------------------------------------
// tb_handshake_const_eq_buffered
// Self-checking bench. The reference model is a depth-2 FIFO of expected
// equality bits (queue), with readiness = room in the FIFO and validity =
// FIFO non-empty. Stats build also models a saturating match counter.
// -----------------------------------------------------------------------------
module tb_handshake_const_eq_buffered;

    localparam int DW = 32;
    localparam logic [DW-1:0] CONST_V = 32'hFFFF_FFFF;
`ifdef HANDSHAKE_CONST_EQ_STATS_EN
    localparam int CW = 4;
    localparam int CMAX = 15;
    logic [CW-1:0] match_count;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] ins;
    logic          ins_valid;
    logic          ins_ready;
    logic          result;
    logic          result_valid;
    logic          result_ready;

    int n_checks = 0;
    int n_pass   = 0;

    bit q[$];
    int exp_cnt = 0;

    always #5 clk = ~clk;

    handshake_const_eq_buffered #(
        .DATA_WIDTH  (DW),
        .CONST_VALUE (CONST_V)
`ifdef HANDSHAKE_CONST_EQ_STATS_EN
        ,
        .COUNT_WIDTH (CW)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ins          (ins),
        .ins_valid    (ins_valid),
        .ins_ready    (ins_ready),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
`ifdef HANDSHAKE_CONST_EQ_STATS_EN
        ,
        .match_count  (match_count)
`endif
    );

    function automatic bit m_ready();
        return (rst == 1'b0) && (q.size() < 2);
    endfunction

    function automatic bit m_valid();
        return (rst == 1'b0) && (q.size() > 0);
    endfunction

    function automatic bit m_result();
        return m_valid() ? q[0] : 1'b0;
    endfunction

    // Apply inputs (called just after a rising edge) and move to the falling edge.
    task automatic drive(input bit v, input logic [DW-1:0] d, input bit rr);
        ins_valid    = v;
        ins          = d;
        result_ready = rr;
        @(negedge clk);
    endtask

    // Advance the model across the next rising edge.
    task automatic advance();
        bit acc, snd, eq;
        acc = ins_valid && m_ready();
        snd = m_valid() && result_ready;
        eq  = (ins == CONST_V);
        @(posedge clk);
        if (rst) begin
            q.delete();
            exp_cnt = 0;
        end else begin
            if (snd) void'(q.pop_front());
            if (acc) q.push_back(eq);
            if (acc && eq && exp_cnt < 15) exp_cnt++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 1'b1);
            n_checks++;
            if (ins_ready !== 1'b0 || result_valid !== 1'b0 || result !== 1'b0)
                $display("FAIL reset_hold: ready=%b valid=%b result=%b want 0 0 0",
                         ins_ready, result_valid, result);
            else n_pass++;
            advance();
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b1);
            n_checks++;
            if (ins_ready !== 1'b1 || result_valid !== 1'b0)
                $display("FAIL reset_release: ready=%b valid=%b want 1 0", ins_ready, result_valid);
            else n_pass++;
`ifdef HANDSHAKE_CONST_EQ_STATS_EN
            n_checks++;
            if (match_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", match_count);
            else n_pass++;
`endif
            advance();
        end
    endtask

    task automatic test_stream();
        logic [DW-1:0] toks [4];
        bit            exp_r [4];
        toks = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        exp_r = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(i < 4, (i < 4) ? toks[i] : 32'h0, 1'b1);
            n_checks++;
            if (ins_ready !== m_ready() || result_valid !== m_valid() ||
                (m_valid() && result !== m_result()))
                $display("FAIL stream_model c%0d: ready=%b valid=%b result=%b want %b %b %b",
                         i, ins_ready, result_valid, result, m_ready(), m_valid(), m_result());
            else n_pass++;
            if (i >= 1 && i <= 4) begin
                n_checks++;
                if (result_valid !== 1'b1 || result !== exp_r[i-1])
                    $display("FAIL stream_token%0d: valid=%b result=%b want 1 %b",
                             i - 1, result_valid, result, exp_r[i-1]);
                else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        // Fill: two accepts with downstream stalled.
        drive(1'b1, 32'hFFFF_FFFF, 1'b0);
        n_checks++;
        if (ins_ready !== 1'b1 || result_valid !== 1'b0)
            $display("FAIL bp_first: ready=%b valid=%b want 1 0", ins_ready, result_valid);
        else n_pass++;
        advance();
        drive(1'b1, 32'h5, 1'b0);
        n_checks++;
        if (ins_ready !== 1'b1 || result_valid !== 1'b1 || result !== 1'b1)
            $display("FAIL bp_second: ready=%b valid=%b result=%b want 1 1 1",
                     ins_ready, result_valid, result);
        else n_pass++;
        advance();
        // Third token is held off for a few cycles; head result stays stable.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 1'b0);
            n_checks++;
            if (ins_ready !== 1'b0 || result_valid !== 1'b1 || result !== 1'b1)
                $display("FAIL bp_full c%0d: ready=%b valid=%b result=%b want 0 1 1",
                         i, ins_ready, result_valid, result);
            else n_pass++;
            advance();
        end
        // Drain.
        drive(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (ins_ready !== 1'b0 || result_valid !== 1'b1 || result !== 1'b1)
            $display("FAIL bp_drain1: ready=%b valid=%b result=%b want 0 1 1",
                     ins_ready, result_valid, result);
        else n_pass++;
        advance();
        drive(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (ins_ready !== 1'b1 || result_valid !== 1'b1 || result !== 1'b0)
            $display("FAIL bp_drain2: ready=%b valid=%b result=%b want 1 1 0",
                     ins_ready, result_valid, result);
        else n_pass++;
        advance();
        drive(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (ins_ready !== 1'b1 || result_valid !== 1'b0)
            $display("FAIL bp_empty: ready=%b valid=%b want 1 0", ins_ready, result_valid);
        else n_pass++;
        advance();
    endtask

    task automatic test_random_alternate();
        int accepted = 0, dut_sends = 0, cyc = 0, bad = 0;
        bit rr = 1'b0;
        while ((accepted < 1000 || q.size() > 0) && cyc < 5000) begin
            bit v;
            logic [DW-1:0] d;
            v = (accepted < 1000);
            d = ($urandom_range(0, 3) == 0) ? CONST_V : DW'($urandom);
            drive(v, d, rr);
            if (ins_ready !== m_ready() || result_valid !== m_valid() ||
                (m_valid() && result !== m_result())) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL alt_model cyc%0d: ready=%b valid=%b result=%b want %b %b %b",
                             cyc, ins_ready, result_valid, result, m_ready(), m_valid(), m_result());
            end
            if (result_valid === 1'b1 && result_ready) dut_sends++;
            if (v && m_ready()) accepted++;
            advance();
            rr = (accepted < 1000) ? ~rr : 1'b1;
            cyc++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL alt_model_total: %0d bad cycles want 0", bad);
        else n_pass++;
        n_checks++;
        if (cyc >= 5000) $display("FAIL alt_timeout: cycles=%0d want <5000", cyc);
        else n_pass++;
        n_checks++;
        if (dut_sends != 1000) $display("FAIL alt_send_count: got %0d want 1000", dut_sends);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        drive(1'b1, CONST_V, 1'b0);
        advance();
        drive(1'b1, CONST_V, 1'b0);
        advance();
        drive(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (ins_ready !== 1'b0 || result_valid !== 1'b1 || result !== 1'b1)
            $display("FAIL mid_full: ready=%b valid=%b result=%b want 0 1 1",
                     ins_ready, result_valid, result);
        else n_pass++;
        advance();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (result_valid !== 1'b0 || result !== 1'b0)
            $display("FAIL mid_in_reset: valid=%b result=%b want 0 0", result_valid, result);
        else n_pass++;
        advance();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1);
            n_checks++;
            if (result_valid !== 1'b0 || ins_ready !== 1'b1)
                $display("FAIL mid_after c%0d: valid=%b ready=%b want 0 1", i, result_valid, ins_ready);
            else n_pass++;
`ifdef HANDSHAKE_CONST_EQ_STATS_EN
            n_checks++;
            if (match_count !== 4'd0) $display("FAIL mid_count: got %0d want 0", match_count);
            else n_pass++;
`endif
            advance();
        end
    endtask

`ifdef HANDSHAKE_CONST_EQ_STATS_EN
    task automatic test_stats_saturation();
        int matches = 0, cyc = 0, bad = 0;
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b1);
        advance();
        rst = 1'b0;
        while (matches < 20 && cyc < 400) begin
            bit mt;
            logic [DW-1:0] d;
            mt = ($urandom_range(0, 1) == 1);
            d  = mt ? CONST_V : (DW'($urandom) & 32'h7FFF_FFFF);
            drive(1'b1, d, ($urandom_range(0, 3) != 0));
            if (match_count !== CW'(exp_cnt)) begin
                bad++;
                if (bad <= 5) $display("FAIL stats_count cyc%0d: got %0d want %0d", cyc, match_count, exp_cnt);
            end
            if (mt && m_ready()) matches++;
            advance();
            cyc++;
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1234, 1'b1);
            advance();
        end
        drive(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (bad != 0) $display("FAIL stats_track: %0d bad cycles want 0", bad);
        else n_pass++;
        n_checks++;
        if (match_count !== 4'd15 || matches < 20)
            $display("FAIL stats_saturate: got %0d (matches %0d) want %0d", match_count, matches, CMAX);
        else n_pass++;
        advance();
    endtask
`endif

    initial begin
        rst          = 1'b1;
        ins          = '0;
        ins_valid    = 1'b0;
        result_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_random_alternate();
        test_mid_reset();
`ifdef HANDSHAKE_CONST_EQ_STATS_EN
        test_stats_saturation();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_handshake_const_eq_buffered
